// File: rtl/io_bscan_bank_ctrl.sv
// rtl/io_bscan_bank_ctrl.sv - boundary-scan chain, update cells and pad muxing for one IO bank column
module io_bscan_bank_ctrl #(
  parameter int NUM_TILES     = 8,
  parameter int PADS_PER_TILE = 2,
  parameter int CNT_W         = 8
) (
  input  logic                                   tclk,
  input  logic                                   r,
  input  logic                                   bs_en,
  input  logic                                   shift,
  input  logic                                   update,
  input  logic                                   hold,
  input  logic                                   mode,
  input  logic                                   hiz_b,
  input  logic [NUM_TILES-1:0]                   tile_bypass,
  input  logic                                   sdi,
  output logic                                   sdo,
  input  logic [NUM_TILES*PADS_PER_TILE-1:0]     padin,
  input  logic [NUM_TILES*PADS_PER_TILE-1:0]     core_pado,
  input  logic [NUM_TILES*PADS_PER_TILE-1:0]     core_padeb,
  output logic [NUM_TILES*PADS_PER_TILE-1:0]     pado,
  output logic [NUM_TILES*PADS_PER_TILE-1:0]     padeb,
  output logic [CNT_W-1:0]                       shift_cnt
);

  localparam int NP = NUM_TILES * PADS_PER_TILE;
  localparam int TW = 3 * PADS_PER_TILE;

  // Per tile, bit 3*j+{0,1,2} holds IN/OUT/OE of local pad j; bit 0 is nearest sdi.
  logic [NUM_TILES-1:0][TW-1:0] sr;
  logic [NUM_TILES-1:0]         byp;
  logic [NP-1:0]                upd_out;
  logic [NP-1:0]                upd_oe;
  logic [NUM_TILES-1:0]         tile_in;
  logic [NUM_TILES-1:0]         tile_out;

  always_comb begin
    tile_out = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      tile_out[t] = tile_bypass[t] ? byp[t] : sr[t][TW-1];
    end
  end

  always_comb begin
    tile_in    = '0;
    tile_in[0] = sdi;
    for (int t = 1; t < NUM_TILES; t++) begin
      tile_in[t] = tile_out[t-1];
    end
  end

  assign sdo = tile_out[NUM_TILES-1];

  always_ff @(posedge tclk) begin
    if (r) begin
      sr        <= '0;
      byp       <= '0;
      upd_out   <= '0;
      upd_oe    <= '1;
      shift_cnt <= '0;
    end else if (bs_en) begin
      if (shift) begin
        if (!hold) begin
          for (int t = 0; t < NUM_TILES; t++) begin
            if (tile_bypass[t]) byp[t] <= tile_in[t];
            else                sr[t]  <= {sr[t][TW-2:0], tile_in[t]};
          end
          if (shift_cnt != '1) shift_cnt <= shift_cnt + CNT_W'(1);
        end
      end else if (update) begin
        for (int p = 0; p < NP; p++) begin
          if (!tile_bypass[p / PADS_PER_TILE]) begin
            upd_out[p] <= sr[p / PADS_PER_TILE][3*(p % PADS_PER_TILE) + 1];
            upd_oe[p]  <= sr[p / PADS_PER_TILE][3*(p % PADS_PER_TILE) + 2];
          end
        end
      end else if (!hold) begin
        for (int p = 0; p < NP; p++) begin
          sr[p / PADS_PER_TILE][3*(p % PADS_PER_TILE)]     <= padin[p];
          sr[p / PADS_PER_TILE][3*(p % PADS_PER_TILE) + 1] <= core_pado[p];
          sr[p / PADS_PER_TILE][3*(p % PADS_PER_TILE) + 2] <= core_padeb[p];
        end
        byp       <= '0;
        shift_cnt <= '0;
      end
    end
  end

  // Bypassed tiles have no meaningful update cells, so EXTEST parks their pads hi-z.
  always_comb begin
    pado  = core_pado;
    padeb = core_padeb;
    for (int p = 0; p < NP; p++) begin
      if (!hiz_b) begin
        padeb[p] = 1'b1;
      end else if (mode) begin
        if (tile_bypass[p / PADS_PER_TILE]) begin
          pado[p]  = 1'b0;
          padeb[p] = 1'b1;
        end else begin
          pado[p]  = upd_out[p];
          padeb[p] = upd_oe[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bscan_bank_ctrl.sv
// tb/tb_io_bscan_bank_ctrl.sv - self-checking bench for io_bscan_bank_ctrl
module tb_io_bscan_bank_ctrl;

  localparam int NT  = 8;
  localparam int PPT = 2;
  localparam int NP  = NT * PPT;

  logic tclk = 1'b0;
  always #5 tclk = ~tclk;

  logic r, bs_en, shift, update, hold, mode, hiz_b, sdi;
  logic [NT-1:0] tile_bypass;
  logic [NP-1:0] padin, core_pado, core_padeb;
  logic          sdo, sdo4;
  logic [NP-1:0] pado, padeb, pado4, padeb4;
  logic [7:0]    shift_cnt;
  logic [3:0]    shift_cnt4;

  io_bscan_bank_ctrl dut (
    .tclk(tclk), .r(r), .bs_en(bs_en), .shift(shift), .update(update), .hold(hold),
    .mode(mode), .hiz_b(hiz_b), .tile_bypass(tile_bypass), .sdi(sdi), .sdo(sdo),
    .padin(padin), .core_pado(core_pado), .core_padeb(core_padeb),
    .pado(pado), .padeb(padeb), .shift_cnt(shift_cnt)
  );

  io_bscan_bank_ctrl #(.CNT_W(4)) dut4 (
    .tclk(tclk), .r(r), .bs_en(bs_en), .shift(shift), .update(update), .hold(hold),
    .mode(mode), .hiz_b(hiz_b), .tile_bypass(tile_bypass), .sdi(sdi), .sdo(sdo4),
    .padin(padin), .core_pado(core_pado), .core_padeb(core_padeb),
    .pado(pado4), .padeb(padeb4), .shift_cnt(shift_cnt4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: cells indexed 3*pad + {0 IN, 1 OUT, 2 OE}.
  bit m_sh [3*NP];
  bit m_byp[NT];
  bit m_uo [NP];
  bit m_ue [NP];
  int m_cnt, m_cnt4;
  int refs[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active chain as a list of cell references from sdi to sdo; negative = bypass cell.
  function automatic void build_refs();
    refs.delete();
    for (int t = 0; t < NT; t++) begin
      if (tile_bypass[t]) refs.push_back(-1 - t);
      else for (int k = 0; k < 3*PPT; k++) refs.push_back(3*PPT*t + k);
    end
  endfunction

  function automatic bit ref_val(input int idx);
    return (idx >= 0) ? m_sh[idx] : m_byp[-idx-1];
  endfunction

  function automatic bit m_sdo();
    build_refs();
    return ref_val(refs[refs.size()-1]);
  endfunction

  function automatic void model_shift(input bit din);
    bit vals[$];
    build_refs();
    foreach (refs[i]) vals.push_back(ref_val(refs[i]));
    vals.push_front(din);
    void'(vals.pop_back());
    foreach (refs[i]) begin
      if (refs[i] >= 0) m_sh[refs[i]] = vals[i];
      else              m_byp[-refs[i]-1] = vals[i];
    end
  endfunction

  function automatic void model_step();
    if (r) begin
      foreach (m_sh[i]) m_sh[i] = 0;
      foreach (m_byp[i]) m_byp[i] = 0;
      foreach (m_uo[i]) begin m_uo[i] = 0; m_ue[i] = 1; end
      m_cnt = 0; m_cnt4 = 0;
    end else if (bs_en) begin
      if (shift) begin
        if (!hold) begin
          model_shift(sdi);
          if (m_cnt < 255) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
      end else if (update) begin
        for (int p = 0; p < NP; p++)
          if (!tile_bypass[p/PPT]) begin m_uo[p] = m_sh[3*p+1]; m_ue[p] = m_sh[3*p+2]; end
      end else if (!hold) begin
        for (int p = 0; p < NP; p++) begin
          m_sh[3*p] = padin[p]; m_sh[3*p+1] = core_pado[p]; m_sh[3*p+2] = core_padeb[p];
        end
        foreach (m_byp[i]) m_byp[i] = 0;
        m_cnt = 0; m_cnt4 = 0;
      end
    end
  endfunction

  function automatic logic [NP-1:0] exp_pado();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++)
      v[p] = (hiz_b && mode) ? (tile_bypass[p/PPT] ? 1'b0 : m_uo[p]) : core_pado[p];
    return v;
  endfunction

  function automatic logic [NP-1:0] exp_padeb();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++)
      v[p] = !hiz_b ? 1'b1 : !mode ? core_padeb[p] : tile_bypass[p/PPT] ? 1'b1 : m_ue[p];
    return v;
  endfunction

  task automatic chk_model();
    #1;
    cmp("mdl_sdo", sdo, m_sdo());
    cmp("mdl_pado", pado, exp_pado());
    cmp("mdl_padeb", padeb, exp_padeb());
    cmp("mdl_cnt", shift_cnt, m_cnt);
    cmp("mdl_cnt4", shift_cnt4, m_cnt4);
  endtask

  task automatic tick();
    model_step();
    @(negedge tclk);
    #1;
  endtask

  task automatic quiet();
    r = 0; bs_en = 0; shift = 0; update = 0; hold = 0; sdi = 0;
  endtask

  task automatic do_reset();
    quiet(); r = 1; tick(); r = 0;
  endtask

  task automatic capture();
    quiet(); bs_en = 1; tick();
  endtask

  typedef struct {
    logic          mode, hiz_b;
    logic [NP-1:0] cp, ce, e_pado, e_padeb;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] pi, co, ce;
    int n;
    bit e;

    tbl[0] = '{1'b1, 1'b1, 16'h1234, 16'h00FF, 16'h0000, 16'hFFFF};
    tbl[1] = '{1'b0, 1'b1, 16'h1234, 16'h00FF, 16'h1234, 16'h00FF};
    tbl[2] = '{1'b0, 1'b0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'hFFFF};
    tbl[3] = '{1'b1, 1'b0, 16'h5555, 16'h0F0F, 16'h5555, 16'hFFFF};
    tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'hFFFF, 16'hA5A5};

    tile_bypass = '0; mode = 1; hiz_b = 1;
    padin = '0; core_pado = '0; core_padeb = '0;
    quiet();
    @(negedge tclk); #1;
    do_reset();

    // Reset state and combinational pad muxing with frozen scan state
    foreach (tbl[i]) begin
      mode = tbl[i].mode; hiz_b = tbl[i].hiz_b;
      core_pado = tbl[i].cp; core_padeb = tbl[i].ce;
      #1;
      cmp("tbl_pado", pado, tbl[i].e_pado);
      cmp("tbl_padeb", padeb, tbl[i].e_padeb);
      cmp("tbl_sdo", sdo, 0);
      cmp("tbl_cnt", shift_cnt, 0);
      tick();
    end

    // Capture then serialise: pad15 OE, OUT, IN ... pad0 IN
    pi = 16'hA5A5; co = 16'h0F0F; ce = 16'h00FF;
    padin = pi; core_pado = co; core_padeb = ce; mode = 0;
    capture();
    shift = 1; sdi = 0;
    for (int i = 0; i < 48; i++) begin
      n = 15 - i/3;
      e = (i%3 == 0) ? ce[n] : (i%3 == 1) ? co[n] : pi[n];
      #1 cmp("shift_out", sdo, e);
      tick();
    end
    cmp("cnt_48", shift_cnt, 48);

    // EXTEST: load OUT=1, OE=0 in every pad and update
    for (int i = 0; i < 48; i++) begin
      sdi = ((47 - i) % 3 == 1);
      tick();
    end
    shift = 0; update = 1; tick();
    quiet(); mode = 1; hiz_b = 1; core_pado = 16'h3C3C;
    #1 cmp("extest_pado", pado, 16'hFFFF);
    cmp("extest_padeb", padeb, 16'h0000);
    hiz_b = 0;
    #1 cmp("hiz_padeb", padeb, 16'hFFFF);
    cmp("hiz_pado", pado, 16'h3C3C);
    hiz_b = 1;

    // shift+update: shift only
    bs_en = 1; shift = 1; update = 1; sdi = 1; tick();
    cmp("su_pado", pado, 16'hFFFF);
    cmp("su_padeb", padeb, 16'h0000);
    cmp("su_cnt", shift_cnt, 97);
    chk_model();
    // hold+shift: nothing moves
    update = 0; hold = 1; sdi = 0; tick();
    cmp("hs_cnt", shift_cnt, 97);
    chk_model();
    // hold+update: update still happens
    shift = 0; update = 1; tick();
    cmp("hu_pado", pado, 16'h0000);
    cmp("hu_padeb", padeb, 16'hFFFF);
    chk_model();

    // Bypass of tiles 0 and 7: chain length 38
    tile_bypass = 8'h81; padin = '0; core_pado = '0; core_padeb = '0;
    do_reset();
    capture();
    shift = 1; sdi = 1; tick(); n = 1; sdi = 0;
    while (sdo !== 1'b1 && n < 100) begin tick(); n++; end
    cmp("bypass_latency", n, 38);
    for (int i = 0; i < 38; i++) begin
      sdi = ((37 - i) >= 1 && (37 - i) <= 36 && ((36 - i) % 3 == 1));
      tick();
    end
    shift = 0; update = 1; tick();
    quiet(); mode = 1; hiz_b = 1;
    #1 cmp("byp_pado", pado, 16'h3FFC);
    cmp("byp_padeb", padeb, 16'hC003);
    chk_model();

    // Reset in the middle of a shift sequence
    tile_bypass = '0; padin = '1; core_pado = '1; core_padeb = '1;
    do_reset();
    capture();
    shift = 1; sdi = 1;
    repeat (20) tick();
    cmp("sat_cnt", shift_cnt, 20);
    cmp("sat_cnt4", shift_cnt4, 15);
    r = 1; tick();
    quiet();
    #1 cmp("rst_sdo", sdo, 0);
    cmp("rst_cnt", shift_cnt, 0);
    cmp("rst_padeb", padeb, 16'hFFFF);
    cmp("rst_pado", pado, 16'h0000);
    bs_en = 1; shift = 1; sdi = 0;
    for (int i = 0; i < 48; i++) begin
      #1 cmp("rst_chain_zero", sdo, 0);
      tick();
    end

    // Randomised traffic against the reference model
    for (int seg = 0; seg < 8; seg++) begin
      tile_bypass = NT'($urandom);
      do_reset();
      for (int c = 0; c < 80; c++) begin
        r = ($urandom_range(63) == 0);
        bs_en = ($urandom_range(7) != 0);
        shift = $urandom_range(1);
        update = ($urandom_range(3) == 0);
        hold = ($urandom_range(4) == 0);
        mode = $urandom_range(1);
        hiz_b = ($urandom_range(5) != 0);
        sdi = $urandom_range(1);
        padin = NP'($urandom); core_pado = NP'($urandom); core_padeb = NP'($urandom);
        chk_model();
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bscan_bank_ctrl.md
Name: io_bscan_bank_ctrl

Overview:
- Parametrised boundary-scan controller for one IO bank column of NUM_TILES IO tiles, each carrying PADS_PER_TILE pads.
- Owns the per-pad capture/shift/update cells (input, output, output-enable), the serial sdi→sdo chain across tiles, and the pad output muxing between the fabric and EXTEST.
- Successor to the fixed 8-tile / 2-pad hand-chained column:
  - adds per-tile bypass so unbonded tiles leave the chain;
  - adds a hold freeze;
  - adds a shift-length counter for chain-integrity checks.

Parameters:
- NUM_TILES, 8, number of IO tiles in the bank.
- PADS_PER_TILE, 2, pads per tile.
- CNT_W, 8, width of the shift counter; the counter saturates.
- Derived, not overridable:
  - NP = NUM_TILES*PADS_PER_TILE.
  - Chain length L = 3*PADS_PER_TILE*(number of tiles with tile_bypass=0) + (number of tiles with tile_bypass=1).

Ports:
- tclk  in  1  scan/bank clock; all state changes on its rising edge.
- r  in  1  reset, synchronous, active-high.
- bs_en  in  1  boundary-scan enable; with bs_en=0 the scan state is frozen.
- shift  in  1  shift the chain one position.
- update  in  1  transfer shift cells to update cells.
- hold  in  1  freeze the shift cells (no shift, no capture).
- mode  in  1  1 = EXTEST (pads driven from update cells), 0 = functional.
- hiz_b  in  1  0 forces all pads to hi-z.
- tile_bypass  in  NUM_TILES  static config; 1 = tile replaced by a 1-bit bypass cell.
- sdi  in  1  serial scan in.
- sdo  out  1  serial scan out.
- padin  in  NP  pad receiver values.
- core_pado  in  NP  fabric output data.
- core_padeb  in  NP  fabric output enable, active-low.
- pado  out  NP  to pad drivers.
- padeb  out  NP  to pad drivers, active-low enable.
- shift_cnt  out  CNT_W  shifts since last capture.

Behaviour:
- Cell order per pad, from sdi side: IN, OUT, OE.
- Pads are ordered 0..NP-1, and tiles 0..NUM_TILES-1, from sdi toward sdo.
- Pad p belongs to tile p/PADS_PER_TILE.
- Per-edge priority:
  1. r
  2. bs_en=0 → hold all state
  3. shift
  4. update
  5. capture
- Capture occurs when bs_en=1, shift=0, update=0, hold=0.
- Reset (r=1): on the edge, regardless of other inputs, including mid-shift:
  - all shift cells = 0, bypass cells = 0;
  - update OUT = 0, update OE = 1;
  - shift_cnt = 0.
  - sdo reads 0 in the following cycle.
- Shift (bs_en=1, shift=1, hold=0):
  - every active cell takes its upstream neighbour; the first cell takes sdi.
  - Cells of bypassed tiles are skipped and keep their value; the tile's bypass cell is in the chain instead.
  - shift_cnt increments, saturating at 2^CNT_W-1.
  - shift=1 with update=1: shift only, update ignored.
- Capture (bs_en=1, shift=0, update=0, hold=0):
  - IN ← padin[p], OUT ← core_pado[p], OE ← core_padeb[p];
  - bypass cells ← 0;
  - shift_cnt ← 0.
- hold=1 with bs_en=1:
  - no shift and no capture; shift_cnt holds;
  - update still executes when update=1 and shift=0.
- Update (bs_en=1, update=1, shift=0):
  - update OUT/OE ← shift OUT/OE for non-bypassed tiles;
  - IN cells have no update stage.
- sdo is the registered value of the last active cell; there is no combinational path from sdi to sdo. Latency sdi→sdo = L shift cycles.
- tile_bypass is static. If it changes, behaviour is undefined until the next reset or capture.
- Pad outputs (combinational from registers and inputs):
  - hiz_b=0 → padeb = all 1, pado = core_pado.
  - hiz_b=1, mode=0 → pado = core_pado, padeb = core_padeb.
  - hiz_b=1, mode=1, tile not bypassed → pado = update OUT, padeb = update OE.
  - hiz_b=1, mode=1, tile bypassed → pado = 0, padeb = 1.
- All outputs take their reset values one cycle after r is sampled high. Pad outputs follow the reset update cells: in EXTEST, pads are hi-z after reset.

Test Plan:
- Reset: r=1 for 1 cycle, then mode=1, hiz_b=1 → padeb=16'hFFFF, pado=0, sdo=0, shift_cnt=0.
- Capture/shift-out (default params, no bypass):
  - Stimulus: padin=16'hA5A5, core_pado=16'h0F0F, core_padeb=16'h00FF; capture, then 48 shifts with sdi=0.
  - Response: sdo serialises pad15 OE, OUT, IN down to pad0 IN (first bit 0); shift_cnt=48.
- EXTEST update:
  - Stimulus: shift in pattern setting all OUT=1, OE=0; pulse update; mode=1.
  - Response: pado=16'hFFFF, padeb=0. Then hiz_b=0 → padeb=16'hFFFF.
- Bypass:
  - Stimulus: tile_bypass=8'h81.
  - Response: L=38; a walking 1 on sdi appears on sdo after exactly 38 shifts. In mode=1, pads 0,1,14,15 have padeb=1, pado=0.
- Simultaneous events:
  - shift=update=1 → chain shifts, update cells unchanged.
  - hold=1, shift=1 → chain and shift_cnt unchanged.
  - hold=1, update=1 → update occurs.
- Reset mid-shift and saturation:
  - r asserted after 20 of 48 shifts → all cells 0 next edge, sdo=0.
  - CNT_W=4 with 20 shifts → shift_cnt=15.
